// File: rtl/caf_pkg.sv
// caf_pkg
//   Shared definitions for the correlator dot-product scheduling blocks.
//   Holds the controller state encoding so that the scheduler and any
//   debug/monitor logic agree on the numeric values.
package caf_pkg;

    localparam int CTRL_STATE_W = 2;

    typedef enum logic [CTRL_STATE_W-1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } ctrl_state_t;

endpackage : caf_pkg

// File: rtl/dot_prod_ctrl.sv
// dot_prod_ctrl
//   Sequences a lagged dot-product run: for each shift index it streams
//   `length` reference/received sample pairs out of the sample buffers into
//   the dot-product engine, waits for the engine result, and presents the
//   result on a valid/ready output before moving to the next shift.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start
//   FEED  | issuing buffer reads k = 0..length-1 for the current shift
//   WAIT  | waiting for the engine result (no timeout)
//   OUT   | holding the result until m_axis handshake
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               single-cycle run request (honoured only in IDLE)
//   busy, done          run in progress / one-cycle completion pulse
//   buf_rd_en           read strobe to both sample buffers (1-cycle latency)
//   ref_addr, rx_addr   reference address k, received address k+shift
//   feed_valid          engine input valid, buf_rd_en delayed to match data
//   dp_tvalid/dp_i/dp_q engine result
//   m_axis_tvalid/tready result handshake
//   out_i/out_q/out_shift held result and its shift index
//   overrun             sticky: engine result arrived outside WAIT
module dot_prod_ctrl
    import caf_pkg::*;
#(
    parameter int length              = 5,
    parameter int length_counter_size = 3,
    parameter int num_shifts          = 4,
    parameter int shift_counter_size  = 2,
    parameter int addr_bits           = 4,
    parameter int i_bits              = 24,
    parameter int q_bits              = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          buf_rd_en,
    output logic [addr_bits-1:0]          ref_addr,
    output logic [addr_bits-1:0]          rx_addr,
    output logic                          feed_valid,
    input  logic                          dp_tvalid,
    input  logic [i_bits-1:0]             dp_i,
    input  logic [q_bits-1:0]             dp_q,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [i_bits-1:0]             out_i,
    output logic [q_bits-1:0]             out_q,
    output logic [shift_counter_size-1:0] out_shift,
    output logic                          overrun
);

    localparam int K_W = length_counter_size + 1;
    localparam logic [K_W-1:0]                K_LAST = K_W'(length - 1);
    localparam logic [shift_counter_size-1:0] S_LAST = shift_counter_size'(num_shifts - 1);

    ctrl_state_t                   state;
    logic [K_W-1:0]                k;
    logic [shift_counter_size-1:0] shift;
    logic [K_W-1:0]                k_inc;
    logic [shift_counter_size-1:0] shift_inc;

    assign k_inc     = k + K_W'(1);
    assign shift_inc = shift + shift_counter_size'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            k             <= '0;
            shift         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            buf_rd_en     <= 1'b0;
            feed_valid    <= 1'b0;
            ref_addr      <= '0;
            rx_addr       <= '0;
            m_axis_tvalid <= 1'b0;
            out_i         <= '0;
            out_q         <= '0;
            out_shift     <= '0;
            overrun       <= 1'b0;
        end else begin
            done       <= 1'b0;
            // buffer data appears one cycle after the read strobe
            feed_valid <= buf_rd_en;

            if (dp_tvalid && (state != WAIT)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FEED;
                        k         <= '0;
                        shift     <= '0;
                        busy      <= 1'b1;
                        overrun   <= 1'b0;
                        buf_rd_en <= 1'b1;
                        ref_addr  <= '0;
                        rx_addr   <= '0;
                    end
                end
                FEED: begin
                    if (k == K_LAST) begin
                        state     <= WAIT;
                        buf_rd_en <= 1'b0;
                    end else begin
                        k        <= k_inc;
                        ref_addr <= addr_bits'(k_inc);
                        rx_addr  <= addr_bits'(k_inc) + addr_bits'(shift);
                    end
                end
                WAIT: begin
                    if (dp_tvalid) begin
                        out_i         <= dp_i;
                        out_q         <= dp_q;
                        out_shift     <= shift;
                        m_axis_tvalid <= 1'b1;
                        state         <= OUT;
                    end
                end
                OUT: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        if (shift == S_LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            // next lag starts immediately at k=0
                            state     <= FEED;
                            shift     <= shift_inc;
                            k         <= '0;
                            buf_rd_en <= 1'b1;
                            ref_addr  <= '0;
                            rx_addr   <= addr_bits'(shift_inc);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : dot_prod_ctrl

// File: tb/tb_dot_prod_ctrl.sv
module tb_dot_prod_ctrl;

    localparam int LEN = 5;
    localparam int NSH = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, dp_tvalid, m_axis_tready;
    logic [23:0] dp_i, dp_q;
    logic        busy, done, buf_rd_en, feed_valid, m_axis_tvalid, overrun;
    logic [3:0]  ref_addr, rx_addr;
    logic [23:0] out_i, out_q;
    logic [1:0]  out_shift;

    dot_prod_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .buf_rd_en(buf_rd_en), .ref_addr(ref_addr), .rx_addr(rx_addr),
        .feed_valid(feed_valid), .dp_tvalid(dp_tvalid), .dp_i(dp_i), .dp_q(dp_q),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .out_i(out_i), .out_q(out_q), .out_shift(out_shift), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observation log, filled from pre-edge values at every posedge
    int          rd_ref_q[$];
    int          rd_rx_q[$];
    logic [23:0] res_i_q[$];
    logic [23:0] res_q_q[$];
    int          res_s_q[$];
    int          fv_cnt, lag_errs, done_cnt, hs_cyc, done_cyc, cyc;
    logic        prev_rd, prev_rst;

    // results the bench handed to the engine inside WAIT, in order
    logic [23:0] exp_i_q[$];
    logic [23:0] exp_q_q[$];

    initial begin
        cyc = 0; fv_cnt = 0; lag_errs = 0; done_cnt = 0; hs_cyc = -1; done_cyc = -1;
        prev_rd = 1'b0; prev_rst = 1'b0;
    end

    always begin
        @(posedge clk);
        cyc++;
        if (prev_rst === 1'b1 && feed_valid !== prev_rd) lag_errs++;
        if (feed_valid === 1'b1) fv_cnt++;
        if (buf_rd_en === 1'b1) begin
            rd_ref_q.push_back(int'(ref_addr));
            rd_rx_q.push_back(int'(rx_addr));
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            res_i_q.push_back(out_i);
            res_q_q.push_back(out_q);
            res_s_q.push_back(int'(out_shift));
            hs_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_rd  = buf_rd_en;
        prev_rst = rst_n;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time=%0t required<2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rd_ref_q.delete(); rd_rx_q.delete();
        res_i_q.delete(); res_q_q.delete(); res_s_q.delete();
        exp_i_q.delete(); exp_q_q.delete();
        fv_cnt = 0; lag_errs = 0; done_cnt = 0; hs_cyc = -1; done_cyc = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rd(input logic lvl);
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (buf_rd_en === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            errors++;
            $display("FAIL wait_rd timeout: buf_rd_en=%b required=%b", buf_rd_en, lvl);
        end
    endtask

    // Acts as the dot-product engine and the downstream consumer for n shifts.
    task automatic drive_run(input int n, input int lat, input int stall, input bit drop_start);
        for (int s = 0; s < n; s++) begin
            wait_rd(1'b1);
            wait_rd(1'b0);
            repeat (lat) tick();
            dp_tvalid = 1'b1;
            dp_i = 24'($urandom);
            dp_q = 24'($urandom);
            exp_i_q.push_back(dp_i);
            exp_q_q.push_back(dp_q);
            tick();
            dp_tvalid = 1'b0;
            repeat (stall) tick();
            m_axis_tready = 1'b1;
            if (drop_start && s == n - 1) start = 1'b0;
            tick();
            m_axis_tready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dp_tvalid = 1'b0; m_axis_tready = 1'b0;
        dp_i = '0; dp_q = '0;
        tick(); tick();
        checks++;
        if ({busy, done, buf_rd_en, feed_valid, m_axis_tvalid, overrun} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: busy,done,rd,fv,tvalid,ovr=%b required=000000",
                     {busy, done, buf_rd_en, feed_valid, m_axis_tvalid, overrun});
        end
        checks++;
        if (ref_addr !== 4'd0 || rx_addr !== 4'd0 || out_shift !== 2'd0) begin
            errors++;
            $display("FAIL reset_addr: ref=%0d rx=%0d shift=%0d required 0/0/0",
                     ref_addr, rx_addr, out_shift);
        end
        checks++;
        if (out_i !== 24'd0 || out_q !== 24'd0) begin
            errors++;
            $display("FAIL reset_out: out_i=%h out_q=%h required 0/0", out_i, out_q);
        end
        // start on the very first edge after reset release
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || buf_rd_en !== 1'b1 || ref_addr !== 4'd0 || rx_addr !== 4'd0) begin
            errors++;
            $display("FAIL first_start: busy=%b rd=%b ref=%0d rx=%0d required 1/1/0/0",
                     busy, buf_rd_en, ref_addr, rx_addr);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int idx;
        clear_log();
        pulse_start();
        drive_run(NSH, 3, 0, 1'b0);
        tick(); tick();
        checks++;
        if (rd_ref_q.size() != LEN * NSH) begin
            errors++;
            $display("FAIL basic_rd_count: got=%0d required=%0d", rd_ref_q.size(), LEN * NSH);
        end else begin
            idx = 0;
            for (int s = 0; s < NSH; s++)
                for (int k = 0; k < LEN; k++) begin
                    checks++;
                    if (rd_ref_q[idx] != k || rd_rx_q[idx] != k + s) begin
                        errors++;
                        $display("FAIL basic_addr s=%0d k=%0d: ref=%0d rx=%0d required %0d/%0d",
                                 s, k, rd_ref_q[idx], rd_rx_q[idx], k, k + s);
                    end
                    idx++;
                end
        end
        checks++;
        if (res_i_q.size() != NSH) begin
            errors++;
            $display("FAIL basic_res_count: got=%0d required=%0d", res_i_q.size(), NSH);
        end else begin
            for (int s = 0; s < NSH; s++) begin
                checks++;
                if (res_i_q[s] !== exp_i_q[s] || res_q_q[s] !== exp_q_q[s] || res_s_q[s] != s) begin
                    errors++;
                    $display("FAIL basic_result %0d: i=%h q=%h sh=%0d required %h/%h/%0d",
                             s, res_i_q[s], res_q_q[s], res_s_q[s], exp_i_q[s], exp_q_q[s], s);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != hs_cyc + 1) begin
            errors++;
            $display("FAIL basic_done: count=%0d at=%0d required 1 at %0d",
                     done_cnt, done_cyc, hs_cyc + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_end: busy=%b required=0", busy);
        end
    endtask

    task automatic test_feed_valid();
        clear_log();
        pulse_start();
        drive_run(NSH, $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
        tick(); tick();
        checks++;
        if (lag_errs != 0) begin
            errors++;
            $display("FAIL fv_lag: lag_errors=%0d required=0", lag_errs);
        end
        checks++;
        if (fv_cnt != LEN * NSH) begin
            errors++;
            $display("FAIL fv_count: got=%0d required=%0d", fv_cnt, LEN * NSH);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clear_log();
            pulse_start();
            drive_run(NSH, $urandom_range(0, 6), $urandom_range(0, 5), 1'b0);
            tick(); tick();
            checks++;
            if (res_i_q.size() != NSH || rd_rx_q.size() != LEN * NSH) begin
                errors++;
                $display("FAIL rand_counts run %0d: res=%0d rd=%0d required %0d/%0d",
                         r, res_i_q.size(), rd_rx_q.size(), NSH, LEN * NSH);
            end else begin
                for (int s = 0; s < NSH; s++) begin
                    checks++;
                    if (res_i_q[s] !== exp_i_q[s] || res_q_q[s] !== exp_q_q[s] ||
                        res_s_q[s] != s || rd_rx_q[s * LEN + LEN - 1] != s + LEN - 1) begin
                        errors++;
                        $display("FAIL rand_result run %0d s=%0d: i=%h q=%h sh=%0d rx_last=%0d required %h/%h/%0d/%0d",
                                 r, s, res_i_q[s], res_q_q[s], res_s_q[s], rd_rx_q[s * LEN + LEN - 1],
                                 exp_i_q[s], exp_q_q[s], s, s + LEN - 1);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        pulse_start();
        wait_rd(1'b1);
        wait_rd(1'b0);
        repeat (2) tick();
        dp_tvalid = 1'b1;
        dp_i = 24'h000123;
        dp_q = 24'($urandom);
        exp_i_q.push_back(dp_i);
        exp_q_q.push_back(dp_q);
        tick();
        dp_tvalid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || out_i !== 24'h000123 || out_shift !== 2'd0 || buf_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d: tvalid=%b out_i=%h sh=%0d rd=%b required 1/000123/0/0",
                         c, m_axis_tvalid, out_i, out_shift, buf_rd_en);
            end
            tick();
        end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        checks++;
        if (buf_rd_en !== 1'b1 || ref_addr !== 4'd0 || rx_addr !== 4'd1 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_feed: rd=%b ref=%0d rx=%0d tvalid=%b required 1/0/1/0",
                     buf_rd_en, ref_addr, rx_addr, m_axis_tvalid);
        end
        drive_run(NSH - 1, 1, 0, 1'b0);
        tick(); tick();
        checks++;
        if (res_i_q.size() != NSH || res_i_q[0] !== 24'h000123 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_run: results=%0d first_i=%h done=%0d required %0d/000123/1",
                     res_i_q.size(), (res_i_q.size() > 0) ? res_i_q[0] : 24'hx, done_cnt, NSH);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        start = 1'b1;
        tick();
        drive_run(NSH, 2, 1, 1'b1);
        repeat (4) tick();
        checks++;
        if (res_i_q.size() != NSH || done_cnt != 1 || rd_ref_q.size() != LEN * NSH) begin
            errors++;
            $display("FAIL held_start: results=%0d done=%0d reads=%0d required %0d/1/%0d",
                     res_i_q.size(), done_cnt, rd_ref_q.size(), NSH, LEN * NSH);
        end
        checks++;
        if (busy !== 1'b0 || buf_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL held_start_idle: busy=%b rd=%b required 0/0", busy, buf_rd_en);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start();
        drive_run(2, 1, 0, 1'b0);
        wait_rd(1'b1);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({busy, done, buf_rd_en, feed_valid, m_axis_tvalid, overrun} !== 6'b0 ||
            ref_addr !== 4'd0 || rx_addr !== 4'd0 ||
            out_i !== 24'd0 || out_q !== 24'd0 || out_shift !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b ref=%0d rx=%0d i=%h q=%h sh=%0d required all zero",
                     {busy, done, buf_rd_en, feed_valid, m_axis_tvalid, overrun},
                     ref_addr, rx_addr, out_i, out_q, out_shift);
        end
        rst_n = 1'b1;
        clear_log();
        pulse_start();
        drive_run(NSH, 0, 0, 1'b0);
        tick(); tick();
        checks++;
        if (rd_rx_q.size() != LEN * NSH || res_s_q.size() != NSH) begin
            errors++;
            $display("FAIL mid_reset_rerun: reads=%0d results=%0d required %0d/%0d",
                     rd_rx_q.size(), res_s_q.size(), LEN * NSH, NSH);
        end else begin
            checks++;
            if (rd_rx_q[0] != 0 || rd_rx_q[LEN] != 1 || res_s_q[0] != 0 || res_i_q[0] !== exp_i_q[0]) begin
                errors++;
                $display("FAIL mid_reset_fresh: rx0=%0d rx5=%0d sh0=%0d i0=%h required 0/1/0/%h",
                         rd_rx_q[0], rd_rx_q[LEN], res_s_q[0], res_i_q[0], exp_i_q[0]);
            end
        end
    endtask

    task automatic test_overrun();
        clear_log();
        pulse_start();
        tick();
        dp_tvalid = 1'b1;
        dp_i = 24'hABCDEF;
        dp_q = 24'h654321;
        m_axis_tready = 1'b1;
        tick();
        dp_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        checks++;
        if (overrun !== 1'b1 || m_axis_tvalid !== 1'b0 || buf_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set: overrun=%b tvalid=%b rd=%b required 1/0/1",
                     overrun, m_axis_tvalid, buf_rd_en);
        end
        drive_run(NSH, 1, 0, 1'b0);
        tick(); tick();
        checks++;
        if (res_i_q.size() != NSH || res_i_q[0] !== exp_i_q[0] || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_discard: results=%0d i0=%h overrun=%b required %0d/%h/1",
                     res_i_q.size(), (res_i_q.size() > 0) ? res_i_q[0] : 24'hx,
                     overrun, NSH, exp_i_q[0]);
        end
        pulse_start();
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear: overrun=%b busy=%b required 0/1", overrun, busy);
        end
        drive_run(NSH, 0, 0, 1'b0);
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_feed_valid();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dot_prod_ctrl

// File: doc/dot_prod_ctrl.md
DOT_PROD_CTRL -- requirements
Module: dot_prod_ctrl

Interface
REQ-001 Parameter length, default 5: samples per dot product.
REQ-002 Parameter length_counter_size, default 3: sample counter width minus one; counter is length_counter_size+1 bits.
REQ-003 Parameter num_shifts, default 4: lag shifts per run.
REQ-004 Parameter shift_counter_size, default 2: shift index width.
REQ-005 Parameter addr_bits, default 4: buffer address width; SHALL hold length+num_shifts-2.
REQ-006 Parameters i_bits, q_bits, default 24: result widths.
REQ-007 clk  in  1  sole clock; all state updates on posedge.
REQ-008 rst_n  in  1  synchronous, active-low reset.
REQ-009 start  in  1  single-cycle run request.
REQ-010 busy  out  1  high from accepted start until the run completes.
REQ-011 done  out  1  one-cycle pulse when the last shift result is accepted.
REQ-012 buf_rd_en  out  1  read strobe to reference and received sample buffers (1-cycle read latency).
REQ-013 ref_addr  out  addr_bits  reference buffer address.
REQ-014 rx_addr  out  addr_bits  received buffer address.
REQ-015 feed_valid  out  1  drives dot-product engine m_axis_x_tvalid and m_axis_y_tvalid.
REQ-016 dp_tvalid, dp_i, dp_q  in  1/i_bits/q_bits  engine result valid and value.
REQ-017 m_axis_tvalid, m_axis_tready  out/in  1/1  result output handshake.
REQ-018 out_i, out_q, out_shift  out  i_bits/q_bits/shift_counter_size  held result and its shift index.
REQ-019 overrun  out  1  sticky flag: engine result arrived outside WAIT.

Function
REQ-020 The FSM SHALL have states IDLE, FEED, WAIT, OUT.
REQ-021 IDLE: start=1 -> FEED with shift=0, k=0, busy=1 next cycle; start is ignored in all other states.
REQ-022 FEED: buf_rd_en=1 for exactly length consecutive cycles with ref_addr=k, rx_addr=k+shift, k incrementing 0..length-1.
REQ-023 feed_valid SHALL equal buf_rd_en delayed one cycle (aligned with buffer data).
REQ-024 FEED -> WAIT on the cycle k=length-1 is issued.
REQ-025 WAIT: on dp_tvalid=1 capture dp_i/dp_q into out_i/out_q, out_shift=shift, -> OUT; no timeout.
REQ-026 OUT: m_axis_tvalid=1, out_* held stable until m_axis_tvalid and m_axis_tready both high.
REQ-027 On that handshake: if shift=num_shifts-1 -> IDLE, done=1 for one cycle, busy=0; else shift+1, k=0 -> FEED.
REQ-028 dp_tvalid=1 in IDLE, FEED or OUT SHALL set overrun and be discarded; overrun clears only on reset or accepted start.
REQ-029 Addresses SHALL never exceed length+num_shifts-2; no wrap-around.
REQ-030 m_axis_tready high outside OUT has no effect.

Reset
REQ-031 rst_n=0 at any clk edge, including mid-run: state=IDLE, k=0, shift=0.
REQ-032 Reset values: busy=0, done=0, buf_rd_en=0, feed_valid=0, m_axis_tvalid=0, overrun=0, ref_addr=0, rx_addr=0, out_i=0, out_q=0, out_shift=0.
REQ-033 First start SHALL be honoured on the first clk edge after rst_n returns high.

Structure
REQ-034 State encodings (IDLE=0, FEED=1, WAIT=2, OUT=3) SHALL live in shared package caf_pkg.
REQ-035 No sub-modules inside dot_prod_ctrl; top-level dot_prod_sched instantiates dot_prod_ctrl, dot_prod_pip and two sample buffers.

Verification
REQ-036 Defaults, start pulse, dp_tvalid 3 cycles after WAIT entry, tready=1 -> rx_addr sequences 0-4,1-5,2-6,3-7; four results, out_shift 0..3; done one cycle after fourth handshake.
REQ-037 tready held low 10 cycles in OUT with out_i=0x000123 -> m_axis_tvalid and out_i stable all 10 cycles; next FEED starts cycle after tready rises.
REQ-038 start asserted every cycle during a run -> exactly 4 results, no restart until IDLE.
REQ-039 rst_n=0 during FEED of shift 2 -> all outputs at reset values next cycle; new start gives fresh run from shift 0.
REQ-040 dp_tvalid pulse during FEED -> overrun=1, result discarded; next start clears overrun.
REQ-041 Check feed_valid lags buf_rd_en by exactly 1 cycle, high exactly 5 cycles per shift.
